// File: rtl/av_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : av_video_pkg
// Purpose  : Shared types and helpers for the Adventure Vision video output
//            pipeline: phosphor tint encoding, per-stage video record and
//            LED intensity expansion to 8 bits.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package av_video_pkg;

    localparam int c_COLOR_W = 8;

    typedef enum logic [1:0] {
        TINT_RED   = 2'd0,
        TINT_GREEN = 2'd1,
        TINT_AMBER = 2'd2,
        TINT_WHITE = 2'd3
    } tint_t;

    typedef struct packed {
        logic [c_COLOR_W-1:0] r;
        logic [c_COLOR_W-1:0] g;
        logic [c_COLOR_W-1:0] b;
        logic                 hs;
        logic                 vs;
        logic                 hb;
        logic                 vb;
        logic                 ce;
    } vid_stage_t;

    // MSB-first replication of an in_bits-wide intensity (held in the low
    // bits of lum) across all 8 output bits, so full scale maps to 8'hFF
    // and zero to 8'h00.
    function automatic logic [c_COLOR_W-1:0] expand_lum(
        input logic [c_COLOR_W-1:0] lum,
        input int                   in_bits
    );
        logic [c_COLOR_W-1:0] v;
        logic [2:0]           src;
        v = '0;
        for (int i = 0; i < c_COLOR_W; i++) begin
            src             = 3'(in_bits - 1 - (i % in_bits));
            v[3'(7 - i)]    = lum[src];
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/av_pix_ce_gen.sv
`default_nettype none
// ============================================================================
// Module   : av_pix_ce_gen
// Purpose  : Pixel clock-enable divider. Counts 0..CE_DIV-1 and flags the
//            last count; a resync request restarts the count at zero on the
//            following clock without suppressing the current enable.
// Ports    : clk      - video clock
//            rst_n    - asynchronous active-low reset
//            i_resync - restart divider phase next cycle
//            o_ce     - pixel enable for the sample taken this cycle
// Revision : 1.0 - initial release
// ============================================================================
module av_pix_ce_gen #(
    parameter int CE_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_resync,
    output logic o_ce
);

    localparam int                 c_CNT_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CE_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // With CE_DIV == 1, c_LAST is zero so the counter never leaves zero and
    // the enable is permanently high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_resync || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign o_ce = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/av_video_pipe.sv
`default_nettype none
// ============================================================================
// Module   : av_video_pipe
// Purpose  : Video output pipeline between the Adventure Vision video
//            generator and the mixer. Generates the pixel enable, expands LED
//            intensity to tinted 8-bit RGB, blacks out blanking, delays every
//            field by PIPE_DEPTH clocks and keeps frame/line counters. Tint
//            requests take effect only on a vsync rising edge.
// Ports    : clk_vid_i, reset_n_i            - clock, async active-low reset
//            lum_i                           - pixel intensity (IN_BITS)
//            hsync_i, vsync_i                - syncs, active high
//            hblank_i, vblank_i              - blanks, active high
//            tint_i                          - requested tint
//            resync_en_i                     - realign divider on hsync rise
//            r_o, g_o, b_o                   - delayed pixel colour
//            hsync_o, vsync_o, hblank_o, vblank_o, ce_pix_o - delayed controls
//            tint_active_o                   - tint currently applied
//            frame_cnt_o, line_cnt_o         - frame and line counters
// Revision : 1.0 - initial release
// ============================================================================
module av_video_pipe
    import av_video_pkg::*;
#(
    parameter int         IN_BITS    = 3,
    parameter int         CE_DIV     = 4,
    parameter int         PIPE_DEPTH = 4,
    parameter logic [1:0] TINT_RESET = 2'd0
) (
    input  logic               clk_vid_i,
    input  logic               reset_n_i,
    input  logic [IN_BITS-1:0] lum_i,
    input  logic               hsync_i,
    input  logic               vsync_i,
    input  logic               hblank_i,
    input  logic               vblank_i,
    input  logic [1:0]         tint_i,
    input  logic               resync_en_i,
    output logic [7:0]         r_o,
    output logic [7:0]         g_o,
    output logic [7:0]         b_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               hblank_o,
    output logic               vblank_o,
    output logic               ce_pix_o,
    output logic [1:0]         tint_active_o,
    output logic [15:0]        frame_cnt_o,
    output logic [9:0]         line_cnt_o
);

    localparam logic [9:0] c_LINE_MAX = 10'd1023;

    // Edge detection
    logic r_hs_q;
    logic r_vs_q;
    logic w_hs_rise;
    logic w_vs_rise;
    logic w_ce;

    // Stage 0: raw input capture
    logic [IN_BITS-1:0] r_s0_lum;
    tint_t              r_s0_tint;
    logic               r_s0_hs;
    logic               r_s0_vs;
    logic               r_s0_hb;
    logic               r_s0_vb;
    logic               r_s0_ce;

    // Stage 1 onwards: formatted video records
    logic [7:0]  w_lum8;
    vid_stage_t  w_stg1;
    vid_stage_t  r_stg [1:PIPE_DEPTH-1];

    tint_t       r_tint_active;
    logic [15:0] r_frame_cnt;
    logic [9:0]  r_line_cnt;

    assign w_hs_rise = hsync_i & ~r_hs_q;
    assign w_vs_rise = vsync_i & ~r_vs_q;

    av_pix_ce_gen #(
        .CE_DIV (CE_DIV)
    ) u_ce_gen (
        .clk      (clk_vid_i),
        .rst_n    (reset_n_i),
        .i_resync (resync_en_i & w_hs_rise),
        .o_ce     (w_ce)
    );

    // Stage 0 latches the tint that is active before any vsync update, so
    // the pixel sampled on the vsync edge still uses the old tint.
    always_ff @(posedge clk_vid_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hs_q    <= 1'b0;
            r_vs_q    <= 1'b0;
            r_s0_lum  <= '0;
            r_s0_tint <= TINT_RED;
            r_s0_hs   <= 1'b0;
            r_s0_vs   <= 1'b0;
            r_s0_hb   <= 1'b0;
            r_s0_vb   <= 1'b0;
            r_s0_ce   <= 1'b0;
        end else begin
            r_hs_q    <= hsync_i;
            r_vs_q    <= vsync_i;
            r_s0_lum  <= lum_i;
            r_s0_tint <= r_tint_active;
            r_s0_hs   <= hsync_i;
            r_s0_vs   <= vsync_i;
            r_s0_hb   <= hblank_i;
            r_s0_vb   <= vblank_i;
            r_s0_ce   <= w_ce;
        end
    end

    assign w_lum8 = expand_lum(8'(r_s0_lum), IN_BITS);

    always_comb begin
        w_stg1    = '0;
        w_stg1.hs = r_s0_hs;
        w_stg1.vs = r_s0_vs;
        w_stg1.hb = r_s0_hb;
        w_stg1.vb = r_s0_vb;
        w_stg1.ce = r_s0_ce;
        unique case (r_s0_tint)
            TINT_RED: begin
                w_stg1.r = w_lum8;
            end
            TINT_GREEN: begin
                w_stg1.g = w_lum8;
            end
            TINT_AMBER: begin
                w_stg1.r = w_lum8;
                w_stg1.g = {1'b0, w_lum8[7:1]};
            end
            TINT_WHITE: begin
                w_stg1.r = w_lum8;
                w_stg1.g = w_lum8;
                w_stg1.b = w_lum8;
            end
            default: ;
        endcase
        if (r_s0_hb || r_s0_vb) begin
            w_stg1.r = '0;
            w_stg1.g = '0;
            w_stg1.b = '0;
        end
    end

    always_ff @(posedge clk_vid_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                r_stg[k] <= '0;
            end
        end else begin
            r_stg[1] <= w_stg1;
            for (int k = 2; k < PIPE_DEPTH; k++) begin
                r_stg[k] <= r_stg[k-1];
            end
        end
    end

    // Counters and tint track the live sync edges; they are not delayed.
    // A vsync edge takes priority over a coincident hsync edge.
    always_ff @(posedge clk_vid_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_tint_active <= tint_t'(TINT_RESET);
            r_frame_cnt   <= '0;
            r_line_cnt    <= '0;
        end else if (w_vs_rise) begin
            r_tint_active <= tint_t'(tint_i);
            r_frame_cnt   <= r_frame_cnt + 16'd1;
            r_line_cnt    <= '0;
        end else if (w_hs_rise && (r_line_cnt != c_LINE_MAX)) begin
            r_line_cnt    <= r_line_cnt + 10'd1;
        end
    end

    assign r_o           = r_stg[PIPE_DEPTH-1].r;
    assign g_o           = r_stg[PIPE_DEPTH-1].g;
    assign b_o           = r_stg[PIPE_DEPTH-1].b;
    assign hsync_o       = r_stg[PIPE_DEPTH-1].hs;
    assign vsync_o       = r_stg[PIPE_DEPTH-1].vs;
    assign hblank_o      = r_stg[PIPE_DEPTH-1].hb;
    assign vblank_o      = r_stg[PIPE_DEPTH-1].vb;
    assign ce_pix_o      = r_stg[PIPE_DEPTH-1].ce;
    assign tint_active_o = r_tint_active;
    assign frame_cnt_o   = r_frame_cnt;
    assign line_cnt_o    = r_line_cnt;

endmodule
`default_nettype wire

// File: tb/tb_av_video_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_av_video_pipe
// Purpose  : Self-checking bench for av_video_pipe. Directed phases shape the
//            stimulus (tint, blanking, resync, counters, reset) and a random
//            phase exercises everything together; every cycle is compared
//            against a behavioural model of the output stream.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_av_video_pipe;

    localparam int         IN_BITS    = 3;
    localparam int         CE_DIV     = 4;
    localparam int         PIPE_DEPTH = 4;
    localparam logic [1:0] TINT_RESET = 2'd0;

    logic               clk_vid_i   = 1'b0;
    logic               reset_n_i   = 1'b0;
    logic [IN_BITS-1:0] lum_i       = '0;
    logic               hsync_i     = 1'b0;
    logic               vsync_i     = 1'b0;
    logic               hblank_i    = 1'b0;
    logic               vblank_i    = 1'b0;
    logic [1:0]         tint_i      = 2'd0;
    logic               resync_en_i = 1'b0;
    logic [7:0]         r_o, g_o, b_o;
    logic               hsync_o, vsync_o, hblank_o, vblank_o, ce_pix_o;
    logic [1:0]         tint_active_o;
    logic [15:0]        frame_cnt_o;
    logic [9:0]         line_cnt_o;

    always #5 clk_vid_i = ~clk_vid_i;

    av_video_pipe #(
        .IN_BITS    (IN_BITS),
        .CE_DIV     (CE_DIV),
        .PIPE_DEPTH (PIPE_DEPTH),
        .TINT_RESET (TINT_RESET)
    ) dut (
        .clk_vid_i     (clk_vid_i),
        .reset_n_i     (reset_n_i),
        .lum_i         (lum_i),
        .hsync_i       (hsync_i),
        .vsync_i       (vsync_i),
        .hblank_i      (hblank_i),
        .vblank_i      (vblank_i),
        .tint_i        (tint_i),
        .resync_en_i   (resync_en_i),
        .r_o           (r_o),
        .g_o           (g_o),
        .b_o           (b_o),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .hblank_o      (hblank_o),
        .vblank_o      (vblank_o),
        .ce_pix_o      (ce_pix_o),
        .tint_active_o (tint_active_o),
        .frame_cnt_o   (frame_cnt_o),
        .line_cnt_o    (line_cnt_o)
    );

    // ------------------------------------------------------------------
    // Reference model: a queue of expected output records plus the live
    // divider phase, sync history, tint and counters.
    // ------------------------------------------------------------------
    typedef struct {
        logic [23:0] rgb;
        logic [4:0]  ctl;   // {hs, vs, hb, vb, ce}
    } exp_t;

    exp_t        m_q[$];
    int          m_cnt;
    logic        m_hsq;
    logic        m_vsq;
    logic [1:0]  m_tint;
    logic [15:0] m_frame;
    int          m_line;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Replicate the intensity end to end and keep the top 8 bits.
    function automatic logic [7:0] ref_expand(input int lum);
        longint v;
        int     reps;
        v    = 0;
        reps = (8 + IN_BITS - 1) / IN_BITS;
        for (int k = 0; k < reps; k++) v = (v << IN_BITS) | longint'(lum);
        return 8'(v >> (reps * IN_BITS - 8));
    endfunction

    task automatic model_reset();
        exp_t z;
        z.rgb = '0;
        z.ctl = '0;
        m_q.delete();
        for (int k = 0; k < PIPE_DEPTH - 1; k++) m_q.push_back(z);
        m_cnt   = 0;
        m_hsq   = 1'b0;
        m_vsq   = 1'b0;
        m_tint  = TINT_RESET;
        m_frame = '0;
        m_line  = 0;
    endtask

    task automatic model_step();
        exp_t       e;
        logic [7:0] l;
        logic [7:0] half;
        bit         hr;
        bit         vr;
        hr   = hsync_i && !m_hsq;
        vr   = vsync_i && !m_vsq;
        l    = ref_expand(int'(lum_i));
        half = l / 2;
        case (m_tint)
            2'd0:    e.rgb = {l, 8'h00, 8'h00};
            2'd1:    e.rgb = {8'h00, l, 8'h00};
            2'd2:    e.rgb = {l, half, 8'h00};
            default: e.rgb = {l, l, l};
        endcase
        if (hblank_i || vblank_i) e.rgb = '0;
        e.ctl = {hsync_i, vsync_i, hblank_i, vblank_i, (m_cnt == CE_DIV - 1)};
        m_q.push_back(e);
        m_cnt = (resync_en_i && hr) ? 0 : (m_cnt + 1) % CE_DIV;
        m_hsq = hsync_i;
        m_vsq = vsync_i;
        if (vr) begin
            m_tint  = tint_i;
            m_frame = m_frame + 16'd1;
            m_line  = 0;
        end else if (hr && m_line < 1023) begin
            m_line++;
        end
    endtask

    // One clock: model the sample, let the DUT clock it, compare 1ns later.
    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk_vid_i);
        #1;
        e = m_q.pop_front();
        check("rgb",   {8'h00, r_o, g_o, b_o}, {8'h00, e.rgb});
        check("ctl",   {27'h0, hsync_o, vsync_o, hblank_o, vblank_o, ce_pix_o}, {27'h0, e.ctl});
        check("tint",  {30'h0, tint_active_o}, {30'h0, m_tint});
        check("frame", {16'h0, frame_cnt_o}, {16'h0, m_frame});
        check("line",  {22'h0, line_cnt_o}, 32'(m_line));
    endtask

    task automatic drive(input int lum, input bit hs, input bit vs, input bit hb,
                         input bit vb, input int tint, input bit rs);
        lum_i       = IN_BITS'(lum);
        hsync_i     = hs;
        vsync_i     = vs;
        hblank_i    = hb;
        vblank_i    = vb;
        tint_i      = 2'(tint);
        resync_en_i = rs;
    endtask

    task automatic drive_random();
        if ($urandom_range(0, 5) == 0)  hsync_i  = ~hsync_i;
        if ($urandom_range(0, 39) == 0) vsync_i  = ~vsync_i;
        if ($urandom_range(0, 5) == 0)  hblank_i = ~hblank_i;
        if ($urandom_range(0, 29) == 0) vblank_i = ~vblank_i;
        lum_i       = IN_BITS'($urandom);
        tint_i      = 2'($urandom);
        resync_en_i = 1'($urandom_range(0, 1));
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk_vid_i);
        #1;
        check("rst_rgb",   {8'h00, r_o, g_o, b_o}, 32'h0);
        check("rst_ctl",   {27'h0, hsync_o, vsync_o, hblank_o, vblank_o, ce_pix_o}, 32'h0);
        check("rst_tint",  {30'h0, tint_active_o}, {30'h0, TINT_RESET});
        check("rst_cnt",   {6'h0, frame_cnt_o, line_cnt_o}, 32'h0);
        reset_n_i = 1'b1;

        // Constant mid-grey red
        drive(5, 0, 0, 0, 0, 0, 0);
        repeat (20) tick();
        check("b6_const", {8'h00, r_o, g_o, b_o}, 32'h00B6_0000);

        // Mid-frame tint request must not take effect
        drive(5, 0, 0, 0, 0, 2, 0);
        repeat (10) tick();
        check("tint_hold", {30'h0, tint_active_o}, 32'h0);

        // vsync edge applies amber
        drive(7, 0, 1, 0, 0, 2, 0);
        tick();
        drive(7, 0, 0, 0, 0, 2, 0);
        repeat (10) tick();
        check("amber", {8'h00, r_o, g_o, b_o}, 32'h00FF_7F00);
        check("tint_amber", {30'h0, tint_active_o}, 32'h2);

        // White with a 10-sample hblank window
        drive(7, 0, 1, 0, 0, 3, 0);
        tick();
        drive(7, 0, 0, 0, 0, 3, 0);
        repeat (6) tick();
        drive(7, 0, 0, 1, 0, 3, 0);
        repeat (10) tick();
        drive(7, 0, 0, 0, 0, 3, 0);
        repeat (8) tick();
        check("white", {8'h00, r_o, g_o, b_o}, 32'h00FF_FFFF);

        // hsync rises at assorted divider phases, with and without resync
        for (int rs = 1; rs >= 0; rs--) begin
            for (int k = 0; k < 8; k++) begin
                drive(3, 1, 0, 0, 0, 3, 1'(rs));
                repeat (1 + k) tick();
                drive(3, 0, 0, 0, 0, 3, 1'(rs));
                repeat (3 + k) tick();
            end
        end

        // Line counter: vsync clears, then three hsync rises
        drive(1, 0, 1, 0, 0, 1, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, 0, 1, 0);
            tick();
            drive(1, 0, 0, 0, 0, 1, 0);
            tick();
        end
        check("line3", {22'h0, line_cnt_o}, 32'd3);

        // Coincident hsync/vsync rise: vsync wins
        drive(1, 1, 1, 0, 0, 1, 0);
        tick();
        check("hv_line", {22'h0, line_cnt_o}, 32'd0);
        drive(1, 0, 0, 0, 0, 1, 0);
        tick();

        // Random traffic
        repeat (3000) begin
            drive_random();
            tick();
        end

        // Line counter saturation
        drive(2, 0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 1100; k++) begin
            hsync_i = 1'b1;
            tick();
            hsync_i = 1'b0;
            tick();
        end
        check("line_sat", {22'h0, line_cnt_o}, 32'd1023);

        // Frame counter wrap from preloaded FFFF
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        m_frame = 16'hFFFF;
        vsync_i = 1'b1;
        tick();
        check("frame_wrap", {16'h0, frame_cnt_o}, 32'h0);
        vsync_i = 1'b0;
        tick();

        // Asynchronous reset mid-line with bright white on the outputs
        drive(7, 0, 1, 0, 0, 3, 0);
        tick();
        drive(7, 0, 0, 0, 0, 3, 0);
        repeat (6) tick();
        #2;
        reset_n_i = 1'b0;
        #1;
        check("arst_rgb",  {8'h00, r_o, g_o, b_o}, 32'h0);
        check("arst_ctl",  {27'h0, hsync_o, vsync_o, hblank_o, vblank_o, ce_pix_o}, 32'h0);
        check("arst_tint", {30'h0, tint_active_o}, {30'h0, TINT_RESET});
        check("arst_cnt",  {6'h0, frame_cnt_o, line_cnt_o}, 32'h0);
        repeat (2) @(posedge clk_vid_i);
        #1;
        model_reset();
        reset_n_i = 1'b1;
        repeat (PIPE_DEPTH - 1) begin
            tick();
            check("pre_first", {24'h0, r_o}, 32'h0);
        end
        tick();
        check("first_px", {24'h0, r_o}, 32'hFF);

        repeat (200) begin
            drive_random();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
